// File: rtl/rmt_pkg.sv
// Shared definitions for the RMT action-stage operand crossbar:
// container widths, opcode values, action-entry field positions and
// small helpers used by the crossbar and its per-class lane selectors.
package rmt_pkg;

   // Container widths of the three PHV container classes
   localparam int WIDTH_6B = 48;
   localparam int WIDTH_4B = 32;
   localparam int WIDTH_2B = 16;

   // Opcodes that influence operand routing
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_LOAD  = 4'b1000;
   localparam logic [3:0] OP_ADDI  = 4'b1001;
   localparam logic [3:0] OP_SUBI  = 4'b1010;
   localparam logic [3:0] OP_STORE = 4'b1011;

   // Action entry field positions (src2 and imm overlap on purpose)
   localparam int ACT_OP_LSB   = 21;
   localparam int ACT_OP_W     = 4;
   localparam int ACT_SRC1_LSB = 16;
   localparam int ACT_SRC2_LSB = 11;
   localparam int ACT_SRC_W    = 5;
   localparam int ACT_IMM_LSB  = 0;
   localparam int ACT_IMM_W    = 16;

   // How a lane builds its two operands
   typedef enum logic [1:0] {
      SEL_PASS    = 2'd0,
      SEL_REG_REG = 2'd1,
      SEL_REG_IMM = 2'd2
   } operand_sel_e;

   // Ceiling log2, usable in constant expressions
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Map an opcode to its operand-routing class; load/store only
   // exist on lanes that have a memory path (lsEn)
   function automatic operand_sel_e decodeOp(input logic [3:0] op, input logic lsEn);
      operand_sel_e sel;
      sel = SEL_PASS;
      case (op)
         OP_ADD, OP_SUB:     sel = SEL_REG_REG;
         OP_ADDI, OP_SUBI:   sel = SEL_REG_IMM;
         OP_LOAD, OP_STORE:  sel = lsEn ? SEL_REG_IMM : SEL_PASS;
         default:            sel = SEL_PASS;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/crossbar_lane_sel.sv
// Operand selection for one container class: every lane decodes its own
// action entry and picks container or immediate operands. Source indices
// beyond the class size give a zero operand and raise o_idx_err.
module crossbar_lane_sel
   import rmt_pkg::*;
#(
   parameter int WIDTH   = 48,
   parameter int COUNT   = 8,
   parameter int LS_EN   = 0,
   parameter int ACT_LEN = 25
)(
   input  logic [COUNT*WIDTH-1:0]   i_conts,
   input  logic [COUNT*ACT_LEN-1:0] i_actions,
   output logic [COUNT*WIDTH-1:0]   o_op1,
   output logic [COUNT*WIDTH-1:0]   o_op2,
   output logic                     o_idx_err
);

   // Container lookup that yields zero for indices outside the class
   function automatic logic [WIDTH-1:0] pickCont(input logic [COUNT*WIDTH-1:0] conts,
                                                 input logic [ACT_SRC_W-1:0] idx);
      logic [WIDTH-1:0] value;
      value = '0;
      for (int j = 0; j < COUNT; j++) begin
         if (idx == ACT_SRC_W'(j)) begin
            value = conts[j*WIDTH +: WIDTH];
         end
      end
      return value;
   endfunction

   function automatic logic outOfRange(input logic [ACT_SRC_W-1:0] idx);
      return (int'(idx) >= COUNT);
   endfunction

   logic [ACT_OP_W-1:0]  w_op;
   logic [ACT_SRC_W-1:0] w_src1;
   logic [ACT_SRC_W-1:0] w_src2;
   logic [ACT_IMM_W-1:0] w_imm;
   operand_sel_e         w_sel;

   // Per-lane decode and operand mux; range errors are OR-ed across lanes
   always_comb begin
      o_op1     = '0;
      o_op2     = '0;
      o_idx_err = 1'b0;
      w_op      = '0;
      w_src1    = '0;
      w_src2    = '0;
      w_imm     = '0;
      w_sel     = SEL_PASS;
      for (int i = 0; i < COUNT; i++) begin
         w_op   = i_actions[i*ACT_LEN + ACT_OP_LSB   +: ACT_OP_W];
         w_src1 = i_actions[i*ACT_LEN + ACT_SRC1_LSB +: ACT_SRC_W];
         w_src2 = i_actions[i*ACT_LEN + ACT_SRC2_LSB +: ACT_SRC_W];
         w_imm  = i_actions[i*ACT_LEN + ACT_IMM_LSB  +: ACT_IMM_W];
         w_sel  = decodeOp(w_op, LS_EN != 0);
         case (w_sel)
            SEL_REG_REG: begin
               o_op1[i*WIDTH +: WIDTH] = pickCont(i_conts, w_src1);
               o_op2[i*WIDTH +: WIDTH] = pickCont(i_conts, w_src2);
               o_idx_err = o_idx_err | outOfRange(w_src1) | outOfRange(w_src2);
            end
            SEL_REG_IMM: begin
               o_op1[i*WIDTH +: WIDTH] = pickCont(i_conts, w_src1);
               o_op2[i*WIDTH +: WIDTH] = WIDTH'(w_imm);
               o_idx_err = o_idx_err | outOfRange(w_src1);
            end
            default: begin
               o_op1[i*WIDTH +: WIDTH] = i_conts[i*WIDTH +: WIDTH];
               o_op2[i*WIDTH +: WIDTH] = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/crossbar_v2.sv
// Operand crossbar for one RMT action stage. A PHV and its VLIW action
// word are each captured in a one-entry holding register; once both are
// present and the output slot is free, the decoded operand bundle is
// registered onto the ALU input buses together with the metadata.
module crossbar_v2
   import rmt_pkg::*;
#(
   parameter int STAGE    = 0,
   parameter int NUM_6B   = 8,
   parameter int NUM_4B   = 8,
   parameter int NUM_2B   = 8,
   parameter int META_LEN = 356,
   parameter int ACT_LEN  = 25,
   parameter int PHV_LEN  = NUM_6B*WIDTH_6B + NUM_4B*WIDTH_4B + NUM_2B*WIDTH_2B + META_LEN,
   parameter int NUM_ACT  = NUM_6B + NUM_4B + NUM_2B + 1
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [PHV_LEN-1:0]          phv_in,
   input  logic                        phv_in_valid,
   output logic                        phv_in_ready,
   input  logic [NUM_ACT*ACT_LEN-1:0]  action_in,
   input  logic                        action_in_valid,
   output logic                        action_in_ready,
   output logic                        alu_in_valid,
   input  logic                        alu_in_ready,
   output logic [NUM_6B*WIDTH_6B-1:0]  alu_in_6B_1,
   output logic [NUM_6B*WIDTH_6B-1:0]  alu_in_6B_2,
   output logic [NUM_4B*WIDTH_4B-1:0]  alu_in_4B_1,
   output logic [NUM_4B*WIDTH_4B-1:0]  alu_in_4B_2,
   output logic [NUM_4B*WIDTH_4B-1:0]  alu_in_4B_3,
   output logic [NUM_2B*WIDTH_2B-1:0]  alu_in_2B_1,
   output logic [NUM_2B*WIDTH_2B-1:0]  alu_in_2B_2,
   output logic [META_LEN-1:0]         phv_remain_data,
   output logic                        idx_err
);

   // PHV block offsets: metadata at the LSBs, then 2B, 4B, 6B upward
   localparam int OFF_2B = META_LEN;
   localparam int OFF_4B = OFF_2B + NUM_2B*WIDTH_2B;
   localparam int OFF_6B = OFF_4B + NUM_4B*WIDTH_4B;

   // Entry 0 is never stored, so held entry k sits at (k-1)*ACT_LEN
   localparam int HELD_ACT_LEN = (NUM_ACT-1)*ACT_LEN;
   localparam int ACT_OFF_2B   = 0;
   localparam int ACT_OFF_4B   = NUM_2B*ACT_LEN;
   localparam int ACT_OFF_6B   = (NUM_2B+NUM_4B)*ACT_LEN;

   // Holding registers
   logic [PHV_LEN-1:0]      r_phv_data;
   logic                    r_phv_full;
   logic [HELD_ACT_LEN-1:0] r_act_data;
   logic                    r_act_full;

   // Output registers
   logic                       r_alu_valid;
   logic [NUM_6B*WIDTH_6B-1:0] r_alu_6b_1;
   logic [NUM_6B*WIDTH_6B-1:0] r_alu_6b_2;
   logic [NUM_4B*WIDTH_4B-1:0] r_alu_4b_1;
   logic [NUM_4B*WIDTH_4B-1:0] r_alu_4b_2;
   logic [NUM_4B*WIDTH_4B-1:0] r_alu_4b_3;
   logic [NUM_2B*WIDTH_2B-1:0] r_alu_2b_1;
   logic [NUM_2B*WIDTH_2B-1:0] r_alu_2b_2;
   logic [META_LEN-1:0]        r_remain;
   logic                       r_idx_err;

   // Handshake and decode nets
   logic                       w_fire;
   logic                       w_phv_load;
   logic                       w_act_load;
   logic [NUM_6B*WIDTH_6B-1:0] w_cont_6b;
   logic [NUM_4B*WIDTH_4B-1:0] w_cont_4b;
   logic [NUM_2B*WIDTH_2B-1:0] w_cont_2b;
   logic [NUM_6B*WIDTH_6B-1:0] w_op1_6b;
   logic [NUM_6B*WIDTH_6B-1:0] w_op2_6b;
   logic [NUM_4B*WIDTH_4B-1:0] w_op1_4b;
   logic [NUM_4B*WIDTH_4B-1:0] w_op2_4b;
   logic [NUM_2B*WIDTH_2B-1:0] w_op1_2b;
   logic [NUM_2B*WIDTH_2B-1:0] w_op2_2b;
   logic                       w_err_6b;
   logic                       w_err_4b;
   logic                       w_err_2b;

   // STAGE is informational and the reserved entry 0 is never decoded
   logic [31:0]        w_unused_stage;
   logic [ACT_LEN-1:0] w_unused_entry0;
   assign w_unused_stage  = 32'(STAGE);
   assign w_unused_entry0 = action_in[ACT_LEN-1:0];

   // A bundle issues when both halves are held and the output slot frees up;
   // a holder that issues this cycle can be refilled in the same cycle
   assign w_fire          = r_phv_full & r_act_full & (~r_alu_valid | alu_in_ready);
   assign phv_in_ready    = ~r_phv_full | w_fire;
   assign action_in_ready = ~r_act_full | w_fire;
   assign w_phv_load      = phv_in_valid & phv_in_ready;
   assign w_act_load      = action_in_valid & action_in_ready;

   assign w_cont_6b = r_phv_data[OFF_6B +: NUM_6B*WIDTH_6B];
   assign w_cont_4b = r_phv_data[OFF_4B +: NUM_4B*WIDTH_4B];
   assign w_cont_2b = r_phv_data[OFF_2B +: NUM_2B*WIDTH_2B];

   crossbar_lane_sel #(
      .WIDTH   (WIDTH_6B),
      .COUNT   (NUM_6B),
      .LS_EN   (0),
      .ACT_LEN (ACT_LEN)
   ) u_sel_6b (
      .i_conts   (w_cont_6b),
      .i_actions (r_act_data[ACT_OFF_6B +: NUM_6B*ACT_LEN]),
      .o_op1     (w_op1_6b),
      .o_op2     (w_op2_6b),
      .o_idx_err (w_err_6b)
   );

   crossbar_lane_sel #(
      .WIDTH   (WIDTH_4B),
      .COUNT   (NUM_4B),
      .LS_EN   (1),
      .ACT_LEN (ACT_LEN)
   ) u_sel_4b (
      .i_conts   (w_cont_4b),
      .i_actions (r_act_data[ACT_OFF_4B +: NUM_4B*ACT_LEN]),
      .o_op1     (w_op1_4b),
      .o_op2     (w_op2_4b),
      .o_idx_err (w_err_4b)
   );

   crossbar_lane_sel #(
      .WIDTH   (WIDTH_2B),
      .COUNT   (NUM_2B),
      .LS_EN   (0),
      .ACT_LEN (ACT_LEN)
   ) u_sel_2b (
      .i_conts   (w_cont_2b),
      .i_actions (r_act_data[ACT_OFF_2B +: NUM_2B*ACT_LEN]),
      .o_op1     (w_op1_2b),
      .o_op2     (w_op2_2b),
      .o_idx_err (w_err_2b)
   );

   // Holding registers: capture on handshake, drain on fire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phv_data <= '0;
         r_phv_full <= 1'b0;
         r_act_data <= '0;
         r_act_full <= 1'b0;
      end else begin
         if (w_phv_load) begin
            r_phv_data <= phv_in;
         end
         if (w_act_load) begin
            r_act_data <= action_in[NUM_ACT*ACT_LEN-1:ACT_LEN];
         end
         r_phv_full <= w_phv_load | (r_phv_full & ~w_fire);
         r_act_full <= w_act_load | (r_act_full & ~w_fire);
      end
   end

   // Output bundle: loads only on fire, so it holds while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_valid <= 1'b0;
         r_alu_6b_1  <= '0;
         r_alu_6b_2  <= '0;
         r_alu_4b_1  <= '0;
         r_alu_4b_2  <= '0;
         r_alu_4b_3  <= '0;
         r_alu_2b_1  <= '0;
         r_alu_2b_2  <= '0;
         r_remain    <= '0;
         r_idx_err   <= 1'b0;
      end else if (w_fire) begin
         r_alu_valid <= 1'b1;
         r_alu_6b_1  <= w_op1_6b;
         r_alu_6b_2  <= w_op2_6b;
         r_alu_4b_1  <= w_op1_4b;
         r_alu_4b_2  <= w_op2_4b;
         r_alu_4b_3  <= w_cont_4b;
         r_alu_2b_1  <= w_op1_2b;
         r_alu_2b_2  <= w_op2_2b;
         r_remain    <= r_phv_data[META_LEN-1:0];
         r_idx_err   <= w_err_6b | w_err_4b | w_err_2b;
      end else if (alu_in_ready) begin
         r_alu_valid <= 1'b0;
      end
   end

   assign alu_in_valid    = r_alu_valid;
   assign alu_in_6B_1     = r_alu_6b_1;
   assign alu_in_6B_2     = r_alu_6b_2;
   assign alu_in_4B_1     = r_alu_4b_1;
   assign alu_in_4B_2     = r_alu_4b_2;
   assign alu_in_4B_3     = r_alu_4b_3;
   assign alu_in_2B_1     = r_alu_2b_1;
   assign alu_in_2B_2     = r_alu_2b_2;
   assign phv_remain_data = r_remain;
   assign idx_err         = r_idx_err;

endmodule

// File: tb/tb_crossbar_v2.sv
// Directed bench for crossbar_v2: every container value encodes its
// bundle seed and container index, so expected operands are written
// straight from the action entries that were sent.
module tb_crossbar_v2;

   localparam int NUM_6B   = 8;
   localparam int NUM_4B   = 8;
   localparam int NUM_2B   = 8;
   localparam int META_LEN = 356;
   localparam int ACT_LEN  = 25;
   localparam int PHV_LEN  = NUM_6B*48 + NUM_4B*32 + NUM_2B*16 + META_LEN;
   localparam int NUM_ACT  = NUM_6B + NUM_4B + NUM_2B + 1;
   localparam int ACTW     = NUM_ACT*ACT_LEN;
   localparam int OFF_2B   = META_LEN;
   localparam int OFF_4B   = OFF_2B + NUM_2B*16;
   localparam int OFF_6B   = OFF_4B + NUM_4B*32;

   logic                 clk;
   logic                 rst_n;
   logic [PHV_LEN-1:0]   phv_in;
   logic                 phv_in_valid;
   logic                 phv_in_ready;
   logic [ACTW-1:0]      action_in;
   logic                 action_in_valid;
   logic                 action_in_ready;
   logic                 alu_in_valid;
   logic                 alu_in_ready;
   logic [NUM_6B*48-1:0] alu_in_6B_1;
   logic [NUM_6B*48-1:0] alu_in_6B_2;
   logic [NUM_4B*32-1:0] alu_in_4B_1;
   logic [NUM_4B*32-1:0] alu_in_4B_2;
   logic [NUM_4B*32-1:0] alu_in_4B_3;
   logic [NUM_2B*16-1:0] alu_in_2B_1;
   logic [NUM_2B*16-1:0] alu_in_2B_2;
   logic [META_LEN-1:0]  phv_remain_data;
   logic                 idx_err;

   int nChecks = 0;
   int nFails  = 0;

   // Expected bundle, filled in by each test before checkBundle
   logic [NUM_6B*48-1:0] e61, e62;
   logic [NUM_4B*32-1:0] e41, e42, e43;
   logic [NUM_2B*16-1:0] e21, e22;
   logic [META_LEN-1:0]  eMeta;
   logic                 eErr;
   logic [ACTW-1:0]      act;
   logic [ACTW-1:0]      actErr;
   logic [ACTW-1:0]      actOk;

   crossbar_v2 #(
      .STAGE    (0),
      .NUM_6B   (NUM_6B),
      .NUM_4B   (NUM_4B),
      .NUM_2B   (NUM_2B),
      .META_LEN (META_LEN),
      .ACT_LEN  (ACT_LEN)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .phv_in          (phv_in),
      .phv_in_valid    (phv_in_valid),
      .phv_in_ready    (phv_in_ready),
      .action_in       (action_in),
      .action_in_valid (action_in_valid),
      .action_in_ready (action_in_ready),
      .alu_in_valid    (alu_in_valid),
      .alu_in_ready    (alu_in_ready),
      .alu_in_6B_1     (alu_in_6B_1),
      .alu_in_6B_2     (alu_in_6B_2),
      .alu_in_4B_1     (alu_in_4B_1),
      .alu_in_4B_2     (alu_in_4B_2),
      .alu_in_4B_3     (alu_in_4B_3),
      .alu_in_2B_1     (alu_in_2B_1),
      .alu_in_2B_2     (alu_in_2B_2),
      .phv_remain_data (phv_remain_data),
      .idx_err         (idx_err)
   );

   // 100 MHz-style free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [47:0] cont6(input int s, input int j);
      return {8'h60, 8'(s), 16'h0000, 16'(j)};
   endfunction

   function automatic logic [31:0] cont4(input int s, input int j);
      return {8'h40, 8'(s), 16'(j)};
   endfunction

   function automatic logic [15:0] cont2(input int s, input int j);
      return {4'h2, 4'(s), 8'(j)};
   endfunction

   function automatic logic [META_LEN-1:0] meta(input int s);
      logic [383:0] t;
      t = {12{32'hC0DE0000 | 32'(s)}};
      return t[META_LEN-1:0];
   endfunction

   function automatic logic [PHV_LEN-1:0] buildPhv(input int s);
      logic [PHV_LEN-1:0] p;
      p = '0;
      p[META_LEN-1:0] = meta(s);
      for (int j = 0; j < NUM_2B; j++) p[OFF_2B + j*16 +: 16] = cont2(s, j);
      for (int j = 0; j < NUM_4B; j++) p[OFF_4B + j*32 +: 32] = cont4(s, j);
      for (int j = 0; j < NUM_6B; j++) p[OFF_6B + j*48 +: 48] = cont6(s, j);
      return p;
   endfunction

   function automatic logic [NUM_6B*48-1:0] pass6(input int s);
      logic [NUM_6B*48-1:0] b;
      for (int j = 0; j < NUM_6B; j++) b[j*48 +: 48] = cont6(s, j);
      return b;
   endfunction

   function automatic logic [NUM_4B*32-1:0] pass4(input int s);
      logic [NUM_4B*32-1:0] b;
      for (int j = 0; j < NUM_4B; j++) b[j*32 +: 32] = cont4(s, j);
      return b;
   endfunction

   function automatic logic [NUM_2B*16-1:0] pass2(input int s);
      logic [NUM_2B*16-1:0] b;
      for (int j = 0; j < NUM_2B; j++) b[j*16 +: 16] = cont2(s, j);
      return b;
   endfunction

   function automatic logic [ACT_LEN-1:0] mkReg(input logic [3:0] op, input logic [4:0] s1,
                                               input logic [4:0] s2);
      return {op, s1, s2, 11'b0};
   endfunction

   function automatic logic [ACT_LEN-1:0] mkImm(input logic [3:0] op, input logic [4:0] s1,
                                               input logic [15:0] imm);
      return {op, s1, imm};
   endfunction

   // Expectations for an all-default action word on bundle s
   task automatic expectPass(input int s);
      e61 = pass6(s); e62 = '0;
      e41 = pass4(s); e42 = '0; e43 = pass4(s);
      e21 = pass2(s); e22 = '0;
      eMeta = meta(s); eErr = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkBundle(input string tag);
      checkOutput({tag, ".valid"},  512'(alu_in_valid), 512'(1'b1));
      checkOutput({tag, ".6B_1"},   512'(alu_in_6B_1), 512'(e61));
      checkOutput({tag, ".6B_2"},   512'(alu_in_6B_2), 512'(e62));
      checkOutput({tag, ".4B_1"},   512'(alu_in_4B_1), 512'(e41));
      checkOutput({tag, ".4B_2"},   512'(alu_in_4B_2), 512'(e42));
      checkOutput({tag, ".4B_3"},   512'(alu_in_4B_3), 512'(e43));
      checkOutput({tag, ".2B_1"},   512'(alu_in_2B_1), 512'(e21));
      checkOutput({tag, ".2B_2"},   512'(alu_in_2B_2), 512'(e22));
      checkOutput({tag, ".meta"},   512'(phv_remain_data), 512'(eMeta));
      checkOutput({tag, ".idxErr"}, 512'(idx_err), 512'(eErr));
   endtask

   // Drive one cycle of inputs at a falling edge and let readies settle
   task automatic applyStimulus(input logic pv, input logic [PHV_LEN-1:0] p,
                                input logic av, input logic [ACTW-1:0] a, input logic rdy);
      phv_in_valid    = pv;
      phv_in          = p;
      action_in_valid = av;
      action_in       = a;
      alu_in_ready    = rdy;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      phv_in = '0; phv_in_valid = 1'b0;
      action_in = '0; action_in_valid = 1'b0;
      alu_in_ready = 1'b1;
      tick(); tick();
      $display("[TB] reset state");
      checkOutput("rst.valid",    512'(alu_in_valid), 512'(1'b0));
      checkOutput("rst.phvRdy",   512'(phv_in_ready), 512'(1'b1));
      checkOutput("rst.actRdy",   512'(action_in_ready), 512'(1'b1));
      checkOutput("rst.idxErr",   512'(idx_err), 512'(1'b0));
      checkOutput("rst.6B_1",     512'(alu_in_6B_1), 512'(0));
      checkOutput("rst.meta",     512'(phv_remain_data), 512'(0));
      rst_n = 1'b1;
      tick();

      // PHV first, action three cycles later, register-register on 6B lane 2
      $display("[TB] test 1: PHV then action");
      act = '0;
      act[19*ACT_LEN +: ACT_LEN] = mkReg(4'b0001, 5'd5, 5'd7);
      applyStimulus(1'b1, buildPhv(1), 1'b0, '0, 1'b1);
      checkOutput("t1.phvRdy", 512'(phv_in_ready), 512'(1'b1));
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("t1.phvRdyHeld", 512'(phv_in_ready), 512'(1'b0));
      tick(); tick();
      applyStimulus(1'b0, '0, 1'b1, act, 1'b1);
      checkOutput("t1.actRdy", 512'(action_in_ready), 512'(1'b1));
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("t1.latency", 512'(alu_in_valid), 512'(1'b0));
      tick();
      expectPass(1);
      e61[2*48 +: 48] = cont6(1, 5);
      e62[2*48 +: 48] = cont6(1, 7);
      checkBundle("t1");
      tick();
      checkOutput("t1.drain", 512'(alu_in_valid), 512'(1'b0));

      // Immediates, 4B store, load/store codes on non-4B lanes fall back
      $display("[TB] test 2: immediates and load/store");
      act = '0;
      act[1*ACT_LEN  +: ACT_LEN] = mkImm(4'b1001, 5'd3, 16'hBEEF);
      act[6*ACT_LEN  +: ACT_LEN] = mkImm(4'b1000, 5'd2, 16'h7777);
      act[13*ACT_LEN +: ACT_LEN] = mkImm(4'b1011, 5'd2, 16'h1234);
      act[18*ACT_LEN +: ACT_LEN] = mkImm(4'b1011, 5'd4, 16'h5555);
      act[20*ACT_LEN +: ACT_LEN] = mkImm(4'b1010, 5'd7, 16'hFFFF);
      applyStimulus(1'b1, buildPhv(2), 1'b1, act, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("t2.latency", 512'(alu_in_valid), 512'(1'b0));
      tick();
      expectPass(2);
      e21[0 +: 16]     = cont2(2, 3);
      e22[0 +: 16]     = 16'hBEEF;
      e41[4*32 +: 32]  = cont4(2, 2);
      e42[4*32 +: 32]  = 32'h0000_1234;
      e61[3*48 +: 48]  = cont6(2, 7);
      e62[3*48 +: 48]  = 48'h0000_0000_FFFF;
      checkBundle("t2");
      tick();

      // Out-of-range sources, followed by a clean bundle at the boundary index
      $display("[TB] test 3: index range check");
      actErr = '0;
      actErr[10*ACT_LEN +: ACT_LEN] = mkReg(4'b0001, 5'd8, 5'd0);
      actErr[8*ACT_LEN  +: ACT_LEN] = mkImm(4'b1001, 5'd31, 16'h0001);
      actOk = '0;
      actOk[10*ACT_LEN +: ACT_LEN] = mkReg(4'b0010, 5'd7, 5'd7);
      applyStimulus(1'b1, buildPhv(3), 1'b1, actErr, 1'b1);
      tick();
      applyStimulus(1'b1, buildPhv(4), 1'b1, actOk, 1'b1);
      checkOutput("t3.phvRdy", 512'(phv_in_ready), 512'(1'b1));
      checkOutput("t3.actRdy", 512'(action_in_ready), 512'(1'b1));
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      expectPass(3);
      e41[1*32 +: 32] = 32'h0;
      e42[1*32 +: 32] = cont4(3, 0);
      e21[7*16 +: 16] = 16'h0;
      e22[7*16 +: 16] = 16'h0001;
      eErr = 1'b1;
      checkBundle("t3a");
      tick();
      expectPass(4);
      e41[1*32 +: 32] = cont4(4, 7);
      e42[1*32 +: 32] = cont4(4, 7);
      checkBundle("t3b");
      tick();
      checkOutput("t3.drain", 512'(alu_in_valid), 512'(1'b0));

      // Back-to-back bundles into a stalled output
      $display("[TB] test 4: backpressure");
      applyStimulus(1'b1, buildPhv(10), 1'b1, '0, 1'b0);
      tick();
      applyStimulus(1'b1, buildPhv(11), 1'b1, '0, 1'b0);
      checkOutput("t4.phvRdyB", 512'(phv_in_ready), 512'(1'b1));
      tick();
      applyStimulus(1'b1, buildPhv(12), 1'b1, '0, 1'b0);
      checkOutput("t4.phvRdyC", 512'(phv_in_ready), 512'(1'b0));
      checkOutput("t4.actRdyC", 512'(action_in_ready), 512'(1'b0));
      for (int c = 0; c < 3; c++) begin
         checkOutput("t4.frozenValid", 512'(alu_in_valid), 512'(1'b1));
         checkOutput("t4.frozenMeta", 512'(phv_remain_data), 512'(meta(10)));
         checkOutput("t4.frozen6B", 512'(alu_in_6B_1), 512'(pass6(10)));
         checkOutput("t4.stallRdy", 512'(phv_in_ready), 512'(1'b0));
         tick();
      end
      applyStimulus(1'b1, buildPhv(12), 1'b1, '0, 1'b1);
      checkOutput("t4.resumeRdy", 512'(phv_in_ready), 512'(1'b1));
      checkOutput("t4.resumeMeta", 512'(phv_remain_data), 512'(meta(10)));
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      expectPass(11);
      checkBundle("t4b11");
      tick();
      expectPass(12);
      checkBundle("t4b12");
      tick();
      checkOutput("t4.drain", 512'(alu_in_valid), 512'(1'b0));

      // Action first, then PHV; everything on the default path
      $display("[TB] test 5: action before PHV");
      applyStimulus(1'b0, '0, 1'b1, '0, 1'b1);
      checkOutput("t5.actRdy", 512'(action_in_ready), 512'(1'b1));
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("t5.actRdyHeld", 512'(action_in_ready), 512'(1'b0));
      checkOutput("t5.phvRdy", 512'(phv_in_ready), 512'(1'b1));
      tick();
      applyStimulus(1'b1, buildPhv(5), 1'b0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      checkOutput("t5.latency", 512'(alu_in_valid), 512'(1'b0));
      tick();
      expectPass(5);
      checkBundle("t5");
      tick();

      // Asynchronous reset with a stalled bundle and both holders full
      $display("[TB] test 6: reset mid-operation");
      applyStimulus(1'b1, buildPhv(6), 1'b1, actErr, 1'b0);
      tick();
      applyStimulus(1'b1, buildPhv(7), 1'b1, actErr, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      checkOutput("t6.preErr", 512'(idx_err), 512'(1'b1));
      checkOutput("t6.preRdy", 512'(phv_in_ready), 512'(1'b0));
      rst_n = 1'b0;
      #1;
      checkOutput("t6.valid", 512'(alu_in_valid), 512'(1'b0));
      checkOutput("t6.idxErr", 512'(idx_err), 512'(1'b0));
      checkOutput("t6.6B_1", 512'(alu_in_6B_1), 512'(0));
      checkOutput("t6.4B_3", 512'(alu_in_4B_3), 512'(0));
      checkOutput("t6.2B_2", 512'(alu_in_2B_2), 512'(0));
      checkOutput("t6.meta", 512'(phv_remain_data), 512'(0));
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("t6.noStale", 512'(alu_in_valid), 512'(1'b0));
      end
      checkOutput("t6.phvRdy", 512'(phv_in_ready), 512'(1'b1));
      checkOutput("t6.actRdy", 512'(action_in_ready), 512'(1'b1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
      $finish;
   end

endmodule
